// File: rtl/bin_comp_serial_if.sv
// Handshake and operand/result bundle for the bit-serial comparator.
// master drives requests, slave answers with busy/done and the result flags.
interface bin_comp_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             a_eq_b;
  logic             a_gt_b;
  logic             a_lt_b;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, a_eq_b, a_gt_b, a_lt_b
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, a_eq_b, a_gt_b, a_lt_b
  );
endinterface

// File: rtl/bin_comp_serial.sv
// Bit-serial MSB-first magnitude comparator, signed or unsigned,
// with start/done handshake and optional exit on first differing bit.
module bin_comp_serial #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  bin_comp_serial_if.slave bus
);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic             rs_q, rs_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             dec_q, dec_d;
  logic             dgt_q, dgt_d;
  logic             dlt_q, dlt_d;

  logic bit_a;
  logic bit_b;
  logic differ;
  logic sign_pos;
  logic gt_bit;
  logic lt_bit;
  logic last;

  assign bit_a    = ra_q[idx_q];
  assign bit_b    = rb_q[idx_q];
  assign differ   = bit_a ^ bit_b;
  assign last     = (idx_q == '0);
  assign sign_pos = rs_q && (idx_q == IW'(WIDTH - 1));
  // A set sign bit means the smaller value in two's complement
  assign gt_bit   = sign_pos ? bit_b : bit_a;
  assign lt_bit   = sign_pos ? bit_a : bit_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rs_q    <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      dec_q   <= 1'b0;
      dgt_q   <= 1'b0;
      dlt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rs_q    <= rs_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      dec_q   <= dec_d;
      dgt_q   <= dgt_d;
      dlt_q   <= dlt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rs_d    = rs_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    dec_d   = dec_q;
    dgt_d   = dgt_q;
    dlt_d   = dlt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          ra_d    = bus.a;
          rb_d    = bus.b;
          rs_d    = bus.is_signed;
          idx_d   = IW'(WIDTH - 1);
          busy_d  = 1'b1;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          dec_d   = 1'b0;
          dgt_d   = 1'b0;
          dlt_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (EARLY_EXIT && differ) begin
          gt_d    = gt_bit;
          lt_d    = lt_bit;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (last) begin
          // Fixed-latency mode publishes the first recorded decision
          if (dec_q) begin
            gt_d = dgt_q;
            lt_d = dlt_q;
          end else if (differ) begin
            gt_d = gt_bit;
            lt_d = lt_bit;
          end else begin
            eq_d = 1'b1;
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          if (differ && !dec_q) begin
            dec_d = 1'b1;
            dgt_d = gt_bit;
            dlt_d = lt_bit;
          end
          idx_d = idx_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.a_eq_b = eq_q;
  assign bus.a_gt_b = gt_q;
  assign bus.a_lt_b = lt_q;
endmodule
